// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU request arbiter: widths, op codes, FSM states, op legality.
// Optional feature macro used by this slice: ALU_ARB_RR_EN (round-robin arbitration).
package alu_ctrl_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned FLAG_W = 4;

    localparam logic [OP_W-1:0] OP_IADD = 4'b0000;
    localparam logic [OP_W-1:0] OP_ISUB = 4'b0001;
    localparam logic [OP_W-1:0] OP_ISLL = 4'b1000;
    localparam logic [OP_W-1:0] OP_ISLR = 4'b1001;
    localparam logic [OP_W-1:0] OP_ISRL = 4'b1010;
    localparam logic [OP_W-1:0] OP_ISRA = 4'b1011;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        logic legal;
        case (op)
            OP_IADD, OP_ISUB, OP_ISLL, OP_ISLR, OP_ISRL, OP_ISRA: legal = 1'b1;
            default:                                              legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/arb2.sv
// Two-way combinational arbiter producing a one-hot grant.
// ALU_ARB_RR_EN defined: round-robin against last_grant; otherwise requester 0 has fixed priority.
module arb2 (
    input  logic [1:0] valid,
`ifdef ALU_ARB_RR_EN
    input  logic       last_grant,
`endif
    output logic [1:0] grant
);

    // Select one requester; a lone valid always wins
    always_comb begin
        grant = 2'b00;
`ifdef ALU_ARB_RR_EN
        if (valid == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end else begin
            grant = valid;
        end
`else
        if (valid[0]) begin
            grant = 2'b01;
        end else if (valid[1]) begin
            grant = 2'b10;
        end
`endif
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared combinational ALU and sequences
// IDLE -> EXEC -> RESP per operation. Macro ALU_ARB_RR_EN selects round-robin arbitration.
module alu_arbiter
    import alu_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [FLAG_W-1:0] rsp_flags,
    output logic              rsp_err,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [FLAG_W-1:0] alu_flags,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              gid_q, gid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [FLAG_W-1:0] rsp_flags_q, rsp_flags_d;
    logic              rsp_err_q, rsp_err_d;
    logic [1:0]        grant;
    logic              legal;

`ifdef ALU_ARB_RR_EN
    logic              last_grant_q, last_grant_d;

    arb2 u_arb2 (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .grant      (grant)
    );
`else
    arb2 u_arb2 (
        .valid (({req1_valid, req0_valid})),
        .grant (grant)
    );
`endif

    // Next-state, capture and output decode for the three-phase sequencer
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        gid_d       = gid_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        rsp_err_d   = rsp_err_q;
`ifdef ALU_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        rsp0_valid  = 1'b0;
        rsp1_valid  = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_op      = OP_IADD;
        legal       = op_legal(op_q);

        unique case (state_q)
            StIdle: begin
                if (grant != 2'b00) begin
                    req0_ready = grant[0];
                    req1_ready = grant[1];
                    a_d        = grant[1] ? req1_a  : req0_a;
                    b_d        = grant[1] ? req1_b  : req0_b;
                    op_d       = grant[1] ? req1_op : req0_op;
                    gid_d      = grant[1];
`ifdef ALU_ARB_RR_EN
                    last_grant_d = grant[1];
`endif
                    state_d    = StExec;
                end
            end
            StExec: begin
                // Illegal ops park the ALU on a zero add and report a zeroed result
                if (legal) begin
                    alu_a  = a_q;
                    alu_b  = b_q;
                    alu_op = op_q;
                end
                rsp_data_d  = legal ? alu_out   : '0;
                rsp_flags_d = legal ? alu_flags : '0;
                rsp_err_d   = !legal;
                state_d     = StResp;
            end
            StResp: begin
                rsp0_valid = !gid_q;
                rsp1_valid = gid_q;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase

        rsp_data  = rsp_data_q;
        rsp_flags = rsp_flags_q;
        rsp_err   = rsp_err_q;
        busy      = (state_q != StIdle);
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= OP_IADD;
            gid_q       <= 1'b0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef ALU_ARB_RR_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            gid_q       <= gid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
            rsp_err_q   <= rsp_err_d;
`ifdef ALU_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU and a transaction-level reference model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp1_valid;
    logic [15:0] rsp_data;
    logic [3:0]  rsp_flags;
    logic        rsp_err;
    logic [15:0] alu_a, alu_b;
    logic [3:0]  alu_op;
    logic [15:0] alu_out;
    logic [3:0]  alu_flags;
    logic        busy;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp0_valid (rsp0_valid),
        .rsp1_valid (rsp1_valid),
        .rsp_data   (rsp_data),
        .rsp_flags  (rsp_flags),
        .rsp_err    (rsp_err),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_out    (alu_out),
        .alu_flags  (alu_flags),
        .busy       (busy)
    );

    // Behavioural stand-in for the shared ALU
    function automatic logic [15:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [3:0] op);
        logic [31:0] rot;
        rot = {a, a} >> b[3:0];
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd8:    return a << b;
            4'd9:    return a >> b;
            4'd10:   return rot[15:0];
            4'd11:   return 16'($signed(a) >>> b);
            default: return 16'hDEAD;
        endcase
    endfunction

    function automatic logic [3:0] flag_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [3:0] op);
        logic [15:0] r;
        r = alu_fn(a, b, op);
        return {r == 16'd0, r[15], a[0] ^ b[0], |op};
    endfunction

    assign alu_out   = alu_fn(alu_a, alu_b, alu_op);
    assign alu_flags = flag_fn(alu_a, alu_b, alu_op);

    typedef struct {
        int          id;
        logic [15:0] data;
        logic [3:0]  flags;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   vecs = 0;
    int   errs = 0;
    int   cyc  = 0;

    // Reference model state
    int          next_ok = 0;
    int          last_g  = 1;
    bit          acc0, acc1;
    int          exec_cyc = -1;
    logic [15:0] ex_a, ex_b;
    logic [3:0]  ex_op;
    logic [3:0]  legal_ops [6] = '{4'd0, 4'd1, 4'd8, 4'd9, 4'd10, 4'd11};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit is_legal(input logic [3:0] op);
        return op inside {4'd0, 4'd1, 4'd8, 4'd9, 4'd10, 4'd11};
    endfunction

    // Monitor: pop and compare whenever the DUT presents a response
    exp_t mon_e;
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            mon_e = sb.pop_front();
            vecs++;
            errs++;
            $display("FAIL missing_rsp for requester %0d: got none expected at cycle %0d",
                     mon_e.id, mon_e.cyc);
        end
        if (rsp0_valid || rsp1_valid) begin
            chk("rsp_onehot", {rsp1_valid, rsp0_valid} == 2'b11, 0);
            if (sb.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL unexpected_rsp at cycle %0d: got rsp0=%0b rsp1=%0b expected none",
                         cyc, rsp0_valid, rsp1_valid);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_id", rsp1_valid, mon_e.id);
                chk("rsp_cycle", cyc, mon_e.cyc);
                chk("rsp_data", rsp_data, mon_e.data);
                chk("rsp_flags", rsp_flags, mon_e.flags);
                chk("rsp_err", rsp_err, mon_e.err);
            end
        end
    end

    // One clock of model checking; inputs are updated by the caller after it returns
    task automatic tick();
        int          g;
        logic [15:0] a, b;
        logic [3:0]  op;
        bit          lg;
        exp_t        e;
        @(negedge clk);
        acc0 = 0;
        acc1 = 0;
        if (cyc == exec_cyc) begin
            chk("exec_alu_a", alu_a, ex_a);
            chk("exec_alu_b", alu_b, ex_b);
            chk("exec_alu_op", alu_op, ex_op);
            chk("exec_busy", busy, 1);
        end
        if (rst_n && cyc >= next_ok && (req0_valid || req1_valid)) begin
`ifdef ALU_ARB_RR_EN
            if (req0_valid && req1_valid) g = (last_g == 1) ? 0 : 1;
            else                          g = req1_valid ? 1 : 0;
`else
            g = req0_valid ? 0 : 1;
`endif
            chk("ready0", req0_ready, g == 0);
            chk("ready1", req1_ready, g == 1);
            a  = g ? req1_a  : req0_a;
            b  = g ? req1_b  : req0_b;
            op = g ? req1_op : req0_op;
            lg = is_legal(op);
            e.id    = g;
            e.data  = lg ? alu_fn(a, b, op)  : 16'd0;
            e.flags = lg ? flag_fn(a, b, op) : 4'd0;
            e.err   = !lg;
            e.cyc   = cyc + 2;
            sb.push_back(e);
            exec_cyc = cyc + 1;
            ex_a     = lg ? a  : 16'd0;
            ex_b     = lg ? b  : 16'd0;
            ex_op    = lg ? op : 4'd0;
            next_ok  = cyc + 3;
            last_g   = g;
            if (g == 1) acc1 = 1;
            else        acc0 = 1;
        end else begin
            chk("ready0_idle", req0_ready, 0);
            chk("ready1_idle", req1_ready, 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int n, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] op);
        if (n == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end
    endtask

    task automatic clr_req(input int n);
        if (n == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    task automatic rand_req(input int n);
        logic [3:0] op;
        op = ($urandom_range(0, 9) == 0) ? 4'($urandom) : legal_ops[$urandom_range(0, 5)];
        set_req(n, 16'($urandom), 16'($urandom_range(0, 20)), op);
    endtask

    task automatic run_until_acc(input int n, input int bound);
        bit got;
        got = 0;
        for (int i = 0; i < bound && !got; i++) begin
            tick();
            got = (n == 0) ? acc0 : acc1;
        end
        if (!got) begin
            vecs++;
            errs++;
            $display("FAIL accept_timeout requester %0d: got no grant expected one within %0d",
                     n, bound);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ready", {req1_ready, req0_ready}, 0);
        chk("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_flags", rsp_flags, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_alu", {alu_a, alu_b, alu_op}, 0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        next_ok = cyc;

        // Single IADD from requester 0
        set_req(0, 16'd5, 16'd8, 4'b0000);
        run_until_acc(0, 4);
        clr_req(0);
        repeat (3) tick();

        // Both requesters held valid; the winner is reloaded with a fresh request
        set_req(0, 16'd35, 16'd34, 4'b0001);
        set_req(1, 16'd10, 16'd20, 4'b0000);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (acc0) set_req(0, 16'd100 + 16'(i), 16'd3, 4'b0000);
            if (acc1) clr_req(1);
        end
        clr_req(0);
        if (req1_valid) begin
            run_until_acc(1, 6);
            clr_req(1);
        end
        repeat (3) tick();

        // Illegal op from requester 1
        set_req(1, 16'd7, 16'd9, 4'b0101);
        run_until_acc(1, 4);
        clr_req(1);
        repeat (3) tick();

        // Reset during EXEC drops the in-flight operation
        set_req(0, 16'hFF00, 16'd4, 4'b1011);
        run_until_acc(0, 4);
        clr_req(0);
        rst_n = 1'b0;
        sb.delete();
        tick();
        rst_n    = 1'b1;
        next_ok  = cyc;
        last_g   = 1;
        exec_cyc = -1;
        @(negedge clk);
        chk("rstx_busy", busy, 0);
        chk("rstx_alu_op", alu_op, 0);
        chk("rstx_rsp_err", rsp_err, 0);
        chk("rstx_rsp_data", rsp_data, 0);
        @(posedge clk);
        #1;
        repeat (3) tick();

        // ISLL that shifts everything out
        set_req(0, 16'hFF00, 16'd8, 4'b1000);
        run_until_acc(0, 4);
        clr_req(0);
        repeat (3) tick();

        // Randomized traffic with occasional abandoned requests
        for (int i = 0; i < 600; i++) begin
            tick();
            for (int n = 0; n < 2; n++) begin
                bit acc, vld;
                acc = (n == 0) ? acc0 : acc1;
                vld = (n == 0) ? req0_valid : req1_valid;
                if (acc) begin
                    if ($urandom_range(0, 1) == 0) rand_req(n);
                    else                           clr_req(n);
                end else if (vld) begin
                    if ($urandom_range(0, 99) < 3) clr_req(n);
                end else if ($urandom_range(0, 99) < 30) begin
                    rand_req(n);
                end
            end
        end
        clr_req(0);
        clr_req(1);
        for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
        if (sb.size() != 0) begin
            vecs++;
            errs++;
            $display("FAIL drain: got %0d outstanding expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
